alu_bus_unit: RTL and testbench
===============================

// Module: alu_bus_unit
// PURPOSE
//   Datapath core of the 8-bit accumulator CPU: an 8-way bus multiplexer
//   feeding the B operand of an ALU, and a registered flag file (Z/C/S/O).
//   Operand A comes from the accumulator; the bus also drives register loads.
//   Mux and ALU are combinational; only the flags are clocked.
// PARAMETERS
//   WIDTH  8  datapath width in bits (all vectors below are WIDTH wide)
// PORTS
//   clk          in   1      rising-edge clock
//   rst_n        in   1      asynchronous active-low reset
//   in_a..in_h   in   WIDTH  bus sources 0..7 (A, B, 0, MEM, INSTR, ADDR, PC, 0)
//   bus_slct     in   3      bus source select, 0 = in_a ... 7 = in_h
//   alu_a        in   WIDTH  ALU operand A (accumulator)
//   alu_op       in   3      ALU operation code
//   bus          out  WIDTH  selected bus value, also ALU operand B
//   alu_result   out  WIDTH  ALU result
//   zero/carry/sign/overflow     out 1  combinational flags of current op
//   zero_flag/carry_flag/sign_flag/overflow_flag  out 1  registered flags
// BEHAVIOUR
// - bus = in_<bus_slct>, purely combinational, no X for any legal select.
// - Operands are two's-complement; A = alu_a, B = bus.
// - alu_op: 0 PASS (result=B), 1 ADD (A+B), 2 SUB (A-B), 3 AND, 4 OR,
//   5 XOR, 6 SHL (A<<1), 7 SHR (A>>1, logical).
// - Result truncated to WIDTH bits; wrap-around is modulo 2^WIDTH.
// - zero = (result==0); sign = result[WIDTH-1].
// - carry: ADD = carry-out of unsigned sum; SUB = borrow (1 iff A<B unsigned);
//   SHL = A[MSB] shifted out; SHR = A[0] shifted out; else 0.
// - overflow: ADD = A,B same sign and result sign differs; SUB = A,B signs
//   differ and result sign differs from A; all other ops 0.
// - Signed compare after SUB: A<B iff sign^overflow; A==B iff zero.
// - Flag register: on rising clk, if alu_op != 0 all four registered flags
//   load the combinational flags; if alu_op == 0 (PASS) they hold.
// - rst_n low: all registered flags clear to 0 immediately (async); rst_n
//   release is synchronous to clk; first update on first edge after release.
// - Reset mid-operation discards the pending update; combinational outputs
//   are unaffected by reset (pure functions of inputs).
// - Latency: bus/alu_result/comb flags 0 cycles; registered flags 1 cycle.
// TESTING
//   Mux: in_a..in_h=10..17, sweep bus_slct 0..7 -> bus = 10..17.
//   ADD A=0x7F,B=0x01 -> result 0x80, S=1 O=1 C=0 Z=0; flags latch next edge.
//   ADD A=0xFF,B=0x01 -> result 0x00, Z=1 C=1 O=0 S=0.
//   SUB A=0x03,B=0x05 -> 0xFE, S=1 C=1 O=0; SUB A=0x80,B=0x01 -> 0x7F, O=1.
//   PASS (op 0) B=0x00 after SUB set Z=0 -> result 0, zero=1, zero_flag stays 0.
//   Flags set, assert rst_n low between edges -> all flags 0 at once, hold low.

Source files
------------

// File: rtl/alu_bus_unit.sv
// Datapath core of the 8-bit accumulator CPU.
// An 8-way bus mux drives ALU operand B; the Z/C/S/O flags are registered.
module alu_bus_unit #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic [WIDTH-1:0] in_c,
  input  logic [WIDTH-1:0] in_d,
  input  logic [WIDTH-1:0] in_e,
  input  logic [WIDTH-1:0] in_f,
  input  logic [WIDTH-1:0] in_g,
  input  logic [WIDTH-1:0] in_h,
  input  logic [2:0]       bus_slct,
  input  logic [WIDTH-1:0] alu_a,
  input  logic [2:0]       alu_op,
  output logic [WIDTH-1:0] bus,
  output logic [WIDTH-1:0] alu_result,
  output logic             zero,
  output logic             carry,
  output logic             sign,
  output logic             overflow,
  output logic             zero_flag,
  output logic             carry_flag,
  output logic             sign_flag,
  output logic             overflow_flag
);

  localparam int MSB = WIDTH - 1;

  typedef enum logic [2:0] {
    OP_PASS = 3'd0,
    OP_ADD  = 3'd1,
    OP_SUB  = 3'd2,
    OP_AND  = 3'd3,
    OP_OR   = 3'd4,
    OP_XOR  = 3'd5,
    OP_SHL  = 3'd6,
    OP_SHR  = 3'd7
  } op_e;

  function automatic logic add_ovf(input logic signed [WIDTH-1:0] a,
                                   input logic signed [WIDTH-1:0] b,
                                   input logic signed [WIDTH-1:0] r);
    return (a[MSB] == b[MSB]) && (r[MSB] != a[MSB]);
  endfunction

  function automatic logic sub_ovf(input logic signed [WIDTH-1:0] a,
                                   input logic signed [WIDTH-1:0] b,
                                   input logic signed [WIDTH-1:0] r);
    return (a[MSB] != b[MSB]) && (r[MSB] != a[MSB]);
  endfunction

  logic [WIDTH-1:0] res;
  logic             c_flag;
  logic             o_flag;
  logic [WIDTH:0]   sum_ext;
  logic [WIDTH:0]   diff_ext;
  logic             zero_flag_q, carry_flag_q, sign_flag_q, overflow_flag_q;
  logic             zero_flag_d, carry_flag_d, sign_flag_d, overflow_flag_d;
  logic             flag_load;

  always_comb begin
    bus = in_a;
    unique case (bus_slct)
      3'd0: bus = in_a;
      3'd1: bus = in_b;
      3'd2: bus = in_c;
      3'd3: bus = in_d;
      3'd4: bus = in_e;
      3'd5: bus = in_f;
      3'd6: bus = in_g;
      3'd7: bus = in_h;
      default: bus = in_a;
    endcase
  end

  // One extra bit captures carry-out on ADD and borrow on SUB
  assign sum_ext  = {1'b0, alu_a} + {1'b0, bus};
  assign diff_ext = {1'b0, alu_a} - {1'b0, bus};

  always_comb begin
    res    = bus;
    c_flag = 1'b0;
    o_flag = 1'b0;
    case (op_e'(alu_op))
      OP_PASS: res = bus;
      OP_ADD: begin
        res    = sum_ext[WIDTH-1:0];
        c_flag = sum_ext[WIDTH];
        o_flag = add_ovf(alu_a, bus, sum_ext[WIDTH-1:0]);
      end
      OP_SUB: begin
        res    = diff_ext[WIDTH-1:0];
        c_flag = diff_ext[WIDTH];
        o_flag = sub_ovf(alu_a, bus, diff_ext[WIDTH-1:0]);
      end
      OP_AND: res = alu_a & bus;
      OP_OR:  res = alu_a | bus;
      OP_XOR: res = alu_a ^ bus;
      OP_SHL: begin
        res    = {alu_a[WIDTH-2:0], 1'b0};
        c_flag = alu_a[MSB];
      end
      OP_SHR: begin
        res    = {1'b0, alu_a[WIDTH-1:1]};
        c_flag = alu_a[0];
      end
      default: res = bus;
    endcase
  end

  assign alu_result = res;
  assign zero       = (res == '0);
  assign sign       = res[MSB];
  assign carry      = c_flag;
  assign overflow   = o_flag;

  // PASS leaves the flag file untouched so bus moves do not clobber compares
  assign flag_load       = (alu_op != 3'd0);
  assign zero_flag_d     = flag_load ? zero     : zero_flag_q;
  assign carry_flag_d    = flag_load ? carry    : carry_flag_q;
  assign sign_flag_d     = flag_load ? sign     : sign_flag_q;
  assign overflow_flag_d = flag_load ? overflow : overflow_flag_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      zero_flag_q     <= 1'b0;
      carry_flag_q    <= 1'b0;
      sign_flag_q     <= 1'b0;
      overflow_flag_q <= 1'b0;
    end else begin
      zero_flag_q     <= zero_flag_d;
      carry_flag_q    <= carry_flag_d;
      sign_flag_q     <= sign_flag_d;
      overflow_flag_q <= overflow_flag_d;
    end
  end

  assign zero_flag     = zero_flag_q;
  assign carry_flag    = carry_flag_q;
  assign sign_flag     = sign_flag_q;
  assign overflow_flag = overflow_flag_q;

endmodule

// File: tb/tb_alu_bus_unit.sv
// Directed bench for alu_bus_unit: bus mux, ALU ops, combinational and registered flags.
module tb_alu_bus_unit;

  localparam int WIDTH = 8;

  logic             clk;
  logic             rst_n;
  logic [WIDTH-1:0] in_a, in_b, in_c, in_d, in_e, in_f, in_g, in_h;
  logic [2:0]       bus_slct;
  logic [WIDTH-1:0] alu_a;
  logic [2:0]       alu_op;
  logic [WIDTH-1:0] bus;
  logic [WIDTH-1:0] alu_result;
  logic             zero, carry, sign, overflow;
  logic             zero_flag, carry_flag, sign_flag, overflow_flag;

  int total = 0;
  int bad   = 0;

  alu_bus_unit #(.WIDTH(WIDTH)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_a(in_a), .in_b(in_b), .in_c(in_c), .in_d(in_d),
    .in_e(in_e), .in_f(in_f), .in_g(in_g), .in_h(in_h),
    .bus_slct(bus_slct), .alu_a(alu_a), .alu_op(alu_op),
    .bus(bus), .alu_result(alu_result),
    .zero(zero), .carry(carry), .sign(sign), .overflow(overflow),
    .zero_flag(zero_flag), .carry_flag(carry_flag),
    .sign_flag(sign_flag), .overflow_flag(overflow_flag)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Drive operand A, operand B through in_b, and the opcode
  task automatic apply(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
    alu_op   = op;
    alu_a    = a;
    in_b     = b;
    bus_slct = 3'd1;
    #1;
  endtask

  task automatic chk_comb(input string tag, input logic [7:0] r,
                          input logic z, input logic c, input logic s, input logic o);
    chk({tag, ".res"}, {24'd0, alu_result}, {24'd0, r});
    chk({tag, ".zcso"}, {28'd0, zero, carry, sign, overflow}, {28'd0, z, c, s, o});
  endtask

  task automatic chk_regs(input string tag, input logic z, input logic c,
                          input logic s, input logic o);
    chk({tag, ".flags"}, {28'd0, zero_flag, carry_flag, sign_flag, overflow_flag},
        {28'd0, z, c, s, o});
  endtask

  // Step one edge and check what the flag file latched
  task automatic edge_regs(input string tag, input logic z, input logic c,
                           input logic s, input logic o);
    @(posedge clk);
    #1;
    chk_regs(tag, z, c, s, o);
  endtask

  initial begin
    rst_n    = 1'b0;
    in_a = 8'd10; in_b = 8'd11; in_c = 8'd12; in_d = 8'd13;
    in_e = 8'd14; in_f = 8'd15; in_g = 8'd16; in_h = 8'd17;
    bus_slct = 3'd0;
    alu_a    = 8'h00;
    alu_op   = 3'd1;

    @(posedge clk);
    #1;
    chk_regs("reset", 1'b0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;

    // Bus mux sweep with PASS so flags stay put
    alu_op = 3'd0;
    for (int i = 0; i < 8; i++) begin
      bus_slct = 3'(i);
      #1;
      chk($sformatf("mux%0d", i), {24'd0, bus}, 32'(10 + i));
      chk($sformatf("pass%0d", i), {24'd0, alu_result}, 32'(10 + i));
    end

    @(posedge clk);
    #1;
    chk_regs("pass_hold_reset", 1'b0, 1'b0, 1'b0, 1'b0);

    apply(3'd1, 8'h7F, 8'h01); chk_comb("add7f01", 8'h80, 0, 0, 1, 1);
    edge_regs("add7f01", 0, 0, 1, 1);

    apply(3'd1, 8'hFF, 8'h01); chk_comb("addff01", 8'h00, 1, 1, 0, 0);
    edge_regs("addff01", 1, 1, 0, 0);

    apply(3'd2, 8'h03, 8'h05); chk_comb("sub0305", 8'hFE, 0, 1, 1, 0);
    edge_regs("sub0305", 0, 1, 1, 0);

    apply(3'd2, 8'h80, 8'h01); chk_comb("sub8001", 8'h7F, 0, 0, 0, 1);
    edge_regs("sub8001", 0, 0, 0, 1);

    apply(3'd0, 8'h55, 8'h00); chk_comb("pass00", 8'h00, 1, 0, 0, 0);
    edge_regs("pass00_hold", 0, 0, 0, 1);

    apply(3'd2, 8'h42, 8'h42); chk_comb("sub_eq", 8'h00, 1, 0, 0, 0);
    edge_regs("sub_eq", 1, 0, 0, 0);

    apply(3'd2, 8'h01, 8'h80); chk_comb("sub0180", 8'h81, 0, 1, 1, 1);
    edge_regs("sub0180", 0, 1, 1, 1);

    apply(3'd3, 8'hF0, 8'h3C); chk_comb("and", 8'h30, 0, 0, 0, 0);
    edge_regs("and", 0, 0, 0, 0);

    apply(3'd4, 8'hF0, 8'h3C); chk_comb("or", 8'hFC, 0, 0, 1, 0);
    apply(3'd5, 8'hF0, 8'h3C); chk_comb("xor", 8'hCC, 0, 0, 1, 0);
    apply(3'd6, 8'h81, 8'h3C); chk_comb("shl", 8'h02, 0, 1, 0, 0);
    edge_regs("shl", 0, 1, 0, 0);
    apply(3'd7, 8'h81, 8'h3C); chk_comb("shr", 8'h40, 0, 1, 0, 0);
    apply(3'd7, 8'h80, 8'h00); chk_comb("shr80", 8'h40, 0, 0, 0, 0);

    // Async reset between edges with an update pending
    apply(3'd1, 8'hFF, 8'h01);
    edge_regs("pre_rst", 1, 1, 0, 0);
    apply(3'd1, 8'h7F, 8'h01);
    #2;
    rst_n = 1'b0;
    #1;
    chk_regs("rst_async", 0, 0, 0, 0);
    chk_comb("rst_comb", 8'h80, 0, 0, 1, 1);
    edge_regs("rst_held", 0, 0, 0, 0);
    @(negedge clk);
    rst_n = 1'b1;
    edge_regs("rst_release", 0, 0, 1, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
